axon_scan_reader: RTL and testbench
===================================

// Module: axon_scan_reader
// PURPOSE
//  Read-side initiator for the synapse SRAM. Latches a per-timestep axon spike vector and
//  walks the set bits lowest-index first. For each spiking axon it issues one read to the
//  synapse matrix, then streams the returned 32-neuron connection word, tagged with its
//  axon index, to the neuron update stage over a valid/ready interface.
// PARAMETERS
//  NUM_AXONS   256  axons per core; synapse address space
//  AXON_W      8    axon index / SRAM address width (log2 NUM_AXONS)
//  DATA_W      32   connection word width, one bit per neuron
//  FIFO_DEPTH  3    output buffer entries; 3 sustains 1 word/cycle with conn_ready_i=1
// PORTS
//  clk_i         in   1          clock; all logic on posedge
//  rst_i         in   1          synchronous reset, active-high
//  start_i       in   1          1-cycle pulse: latch spikes_i and begin scan (ignored while busy_o)
//  spikes_i      in   NUM_AXONS  axon spike vector; sampled only on an accepted start_i
//  syn_en_o      out  1          synapse SRAM enable (read strobe)
//  syn_we_o      out  1          synapse SRAM write enable; tied 0 (read-only initiator)
//  syn_addr_o    out  AXON_W     synapse SRAM address = axon index
//  syn_data_i    in   DATA_W     connection word; valid exactly 1 cycle after syn_en_o
//  conn_valid_o  out  1          output word valid
//  conn_ready_i  in   1          downstream accepts word
//  conn_data_o   out  DATA_W     connection word
//  conn_axon_o   out  AXON_W     axon index of conn_data_o
//  conn_last_o   out  1          word belongs to the final spiking axon of this scan
//  busy_o        out  1          scan in progress
//  done_o        out  1          1-cycle pulse: scan complete, every word consumed
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; pending vector, in-flight flag and FIFO cleared.
//    Reset mid-scan abandons the scan; an in-flight SRAM word is discarded, no done_o.
//  - FSM: IDLE -(start_i)-> SCAN -(pending==0)-> DRAIN -(!inflight && fifo empty)-> IDLE.
//    done_o asserted in the DRAIN->IDLE cycle. busy_o = (state != IDLE).
//  - start_i in IDLE: pending <= spikes_i, go to SCAN. start_i in SCAN/DRAIN is ignored.
//  - Issue rule (SCAN): syn_en_o=1 iff pending!=0 and (fifo_count + inflight) < FIFO_DEPTH,
//    using registered values only (no same-cycle pop lookahead). syn_addr_o = index of the
//    lowest set bit of pending; that bit clears the same cycle. Tag last = (pending has no
//    other set bit). SRAM outputs are registered by this block (no combinational paths).
//  - Return: inflight_q set on issue. Next cycle, syn_data_i + axon tag + last tag are
//    pushed to the FIFO. The credit rule guarantees no push to a full FIFO; overflow is
//    an assertion failure, never silent drop.
//  - Output: FWFT FIFO head drives conn_*; pop on conn_valid_o && conn_ready_i. conn_*
//    stay stable while conn_valid_o && !conn_ready_i. Push and pop in the same cycle is legal
//    at any occupancy, including full.
//  - Order: words leave in strictly ascending axon index; one word per set spike bit.
//  - Empty scan (spikes_i==0): SCAN->DRAIN->IDLE, done_o pulses 2 cycles after start_i,
//    no SRAM reads, no output words.
//  - All-zero connection words are still emitted (no filtering).
//  - Latency: start_i at cycle t -> first syn_en_o at t+1 -> conn_valid_o at t+3.
// STRUCTURE
//  - snn_defines.vh (shared): NUM_AXONS, NUM_NEURONS, AXON_W, DATA_W defaults.
//  - Sub-module conn_fifo: FWFT, depth FIFO_DEPTH, width DATA_W+AXON_W+1, with count output.
//  - Top: FSM, pending register, 256-bit lowest-set-bit priority encoder, in-flight tag reg.
// TESTING
//  - Reset: hold rst_i 2 cycles mid-scan -> all outputs 0, no done_o, next start works.
//  - Spikes bits {3,17,255}, SRAM[a]=a*0x01010101, ready=1 -> words (3,0x03030303),
//    (17,0x11111111), (255,0xFFFFFFFF); last only on 255; done_o 1 cycle after final pop.
//  - All 256 bits set, ready=1 -> 256 words in order, issue 1/cycle after first, done_o once.
//  - Backpressure: 8 bits set, ready toggling 1-0-0-1 random -> no loss/dup, conn_* stable
//    while stalled, syn_en_o never raises fifo_count+inflight above 3.
//  - spikes_i=0 -> no syn_en_o, no conn_valid_o, done_o 2 cycles after start_i.
//  - start_i re-pulsed during SCAN with other spikes_i -> ignored; original scan completes.

Source files
------------

// File: rtl/axon_scan_reader_pkg.sv
// Shared constants, types and helpers for the axon scan reader.
package axon_scan_reader_pkg;

  localparam int unsigned NUM_AXONS  = 256;
  localparam int unsigned AXON_W     = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 3;

  localparam int unsigned ENTRY_W = DATA_W + AXON_W + 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain
  } scan_state_e;

  // One buffered output word: connection bits tagged with axon index and last flag.
  typedef struct packed {
    logic              last;
    logic [AXON_W-1:0] axon;
    logic [DATA_W-1:0] data;
  } conn_entry_t;

  // Index of the lowest set bit; 0 when the vector is empty (caller gates on that).
  function automatic logic [AXON_W-1:0] lowest_set_idx(input logic [NUM_AXONS-1:0] vec);
    logic [AXON_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_AXONS) - 1; i >= 0; i--) begin
      if (vec[i]) idx = AXON_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axon_scan_reader_conn_fifo.sv
// First-word-fall-through FIFO with occupancy count. Push into a full FIFO is only
// legal when a pop happens in the same cycle.
module axon_scan_reader_conn_fifo #(
  parameter int unsigned Width = 41,
  parameter int unsigned Depth = 3,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, push_en, pop_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign count   = count_q;
  // Gate the head so the output bus reads zero while nothing is buffered.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage array; contents need no reset since the head is gated by empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

  // Overflow is a design error upstream, never a silent drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop))
        else $error("conn_fifo overflow: push into full FIFO without pop");
    end
  end

endmodule

// File: rtl/axon_scan_reader.sv
// Synapse SRAM read initiator: walks latched spike bits lowest-first, reads one
// connection word per spiking axon and streams tagged words downstream.
module axon_scan_reader
  import axon_scan_reader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NUM_AXONS-1:0] spikes_i,
  output logic                 syn_en_o,
  output logic                 syn_we_o,
  output logic [AXON_W-1:0]    syn_addr_o,
  input  logic [DATA_W-1:0]    syn_data_i,
  output logic                 conn_valid_o,
  input  logic                 conn_ready_i,
  output logic [DATA_W-1:0]    conn_data_o,
  output logic [AXON_W-1:0]    conn_axon_o,
  output logic                 conn_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  scan_state_e          state_q, state_d;
  logic [NUM_AXONS-1:0] pending_q, pending_d;
  logic [NUM_AXONS-1:0] pending_rest;
  logic [AXON_W-1:0]    lowest_idx;
  logic                 inflight_q;
  logic [AXON_W-1:0]    inflight_axon_q;
  logic                 inflight_last_q;
  logic                 issue;
  logic                 done;
  logic [CNT_W:0]       credits_used;

  logic [ENTRY_W-1:0]   fifo_wdata, fifo_rdata;
  logic                 fifo_empty, fifo_pop;
  logic [CNT_W-1:0]     fifo_count;
  conn_entry_t          head;

  // Lowest set bit of pending and the vector with that bit removed.
  assign lowest_idx   = lowest_set_idx(pending_q);
  assign pending_rest = pending_q & (pending_q - NUM_AXONS'(1));

  // Credit check uses registered occupancy only: buffered words plus the one in flight.
  assign credits_used = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight_q);
  assign issue = (state_q == StScan) && (pending_q != '0) &&
                 (credits_used < (CNT_W + 1)'(FIFO_DEPTH));

  // Scan FSM next-state, pending-vector update and done pulse.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          pending_d = spikes_i;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (pending_q == '0) begin
          state_d = StDrain;
        end else if (issue) begin
          pending_d = pending_rest;
        end
      end
      StDrain: begin
        if (!inflight_q && fifo_empty) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and pending vector registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // In-flight tag: remembers which axon the SRAM word arriving next cycle belongs to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q      <= 1'b0;
      inflight_axon_q <= '0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_axon_q <= lowest_idx;
        inflight_last_q <= (pending_rest == '0);
      end
    end
  end

  assign fifo_wdata = {inflight_last_q, inflight_axon_q, syn_data_i};
  assign fifo_pop   = conn_valid_o & conn_ready_i;

  axon_scan_reader_conn_fifo #(
    .Width (ENTRY_W),
    .Depth (FIFO_DEPTH)
  ) u_conn_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (inflight_q),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head = conn_entry_t'(fifo_rdata);

  assign syn_en_o     = issue;
  assign syn_we_o     = 1'b0;
  assign syn_addr_o   = issue ? lowest_idx : '0;
  assign conn_valid_o = ~fifo_empty;
  assign conn_data_o  = head.data;
  assign conn_axon_o  = head.axon;
  assign conn_last_o  = head.last;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done;

endmodule

// File: tb/tb_axon_scan_reader.sv
// Self-checking bench: scoreboard built from the latched spike vector and an SRAM
// model, table-driven scans, random scans and hand-written reset/restart sequences.
module tb_axon_scan_reader;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [255:0] spikes_i;
  logic         syn_en_o, syn_we_o;
  logic [7:0]   syn_addr_o;
  logic [31:0]  syn_data_i = '0;
  logic         conn_valid_o;
  logic         conn_ready_i = 1'b1;
  logic [31:0]  conn_data_o;
  logic [7:0]   conn_axon_o;
  logic         conn_last_o, busy_o, done_o;

  always #5 clk = ~clk;

  axon_scan_reader dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .spikes_i     (spikes_i),
    .syn_en_o     (syn_en_o),
    .syn_we_o     (syn_we_o),
    .syn_addr_o   (syn_addr_o),
    .syn_data_i   (syn_data_i),
    .conn_valid_o (conn_valid_o),
    .conn_ready_i (conn_ready_i),
    .conn_data_o  (conn_data_o),
    .conn_axon_o  (conn_axon_o),
    .conn_last_o  (conn_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM model: word appears one cycle after the read strobe.
  logic [31:0] sram [256];
  always @(posedge clk) if (syn_en_o) syn_data_i <= sram[syn_addr_o];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: always ready, 1: random ready, 2: never ready
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      conn_ready_i = 1'b1;
    else if (ready_mode == 2) conn_ready_i = 1'b0;
    else                      conn_ready_i = 1'($urandom_range(0, 1));
  end

  // Scoreboard and per-scan statistics, owned by the monitor.
  typedef struct {
    int          axon;
    logic [31:0] data;
    logic        last;
  } word_t;
  word_t exp_q[$];

  int start_cyc, first_en_cyc, last_en_cyc, first_valid_cyc, last_pop_cyc, done_cyc;
  int en_count, valid_cycles, words_seen, issued, popped;
  int done_count = 0;
  bit stall_prev = 1'b0;
  logic [40:0] prev_word;

  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      // Outstanding reads (issued but not yet consumed) never exceed three.
      if (syn_en_o) begin
        check("credit_limit", 64'(issued - popped < 3), 64'd1);
        check("syn_we_zero", 64'(syn_we_o), 64'd0);
        if (first_en_cyc < 0) first_en_cyc = cyc;
        last_en_cyc = cyc;
        en_count++;
      end
      if (stall_prev) begin
        check("stall_valid_held", 64'(conn_valid_o), 64'd1);
        check("stall_word_stable", 64'({conn_last_o, conn_axon_o, conn_data_o}),
              64'(prev_word));
      end
      if (conn_valid_o) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("word_expected", 64'(exp_q.size() > 0), 64'd1);
        if (conn_ready_i && exp_q.size() > 0) begin
          word_t e;
          logic [7:0] ea;
          e  = exp_q.pop_front();
          ea = e.axon[7:0];
          check("word", 64'({conn_last_o, conn_axon_o, conn_data_o}),
                64'({e.last, ea, e.data}));
          popped++;
          words_seen++;
          last_pop_cyc = cyc;
        end
      end
      if (syn_en_o) issued++;
      stall_prev = conn_valid_o && !conn_ready_i;
      prev_word  = {conn_last_o, conn_axon_o, conn_data_o};
      if (done_o) begin
        done_count++;
        done_cyc = cyc;
        check("done_all_consumed", 64'(exp_q.size()), 64'd0);
      end
      // Accepted start: expected stream is every set bit in ascending order.
      if (start_i && !busy_o) begin
        int n, k;
        exp_q.delete();
        n = $countones(spikes_i);
        k = 0;
        for (int i = 0; i < 256; i++) begin
          if (spikes_i[i]) begin
            word_t w;
            k++;
            w.axon = i;
            w.data = sram[i];
            w.last = (k == n);
            exp_q.push_back(w);
          end
        end
        start_cyc = cyc;
        first_en_cyc = -1; last_en_cyc = -1; first_valid_cyc = -1;
        last_pop_cyc = -1; done_cyc = -1;
        en_count = 0; valid_cycles = 0; words_seen = 0; issued = 0; popped = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup_sram(input int mode);
    for (int a = 0; a < 256; a++) begin
      if (mode == 0)       sram[a] = 32'(a) * 32'h0101_0101;
      else if (a % 5 == 0) sram[a] = '0;
      else                 sram[a] = $urandom();
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int k = 0; k < budget && done_count == d0; k++) tick();
    repeat (4) tick();
    check("done_once", 64'(done_count - d0), 64'd1);
  endtask

  task automatic run_scan(input logic [255:0] sp, input int rm);
    int d0;
    d0 = done_count;
    ready_mode = rm;
    spikes_i = sp;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    spikes_i = {8{$urandom()}};
    wait_done(d0, 4000);
  endtask

  task automatic scan_checks(input int exp_words, input int exp_span);
    check("word_count", 64'(words_seen), 64'(exp_words));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    if (exp_words > 0) begin
      check("first_en_latency", 64'(first_en_cyc - start_cyc), 64'd1);
      check("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
      check("done_after_last_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
    end else begin
      check("empty_done_latency", 64'(done_cyc - start_cyc), 64'd2);
      check("empty_no_reads", 64'(en_count), 64'd0);
      check("empty_no_words", 64'(valid_cycles), 64'd0);
    end
    if (exp_span >= 0) begin
      check("issue_count", 64'(en_count), 64'(exp_words));
      check("issue_span", 64'(last_en_cyc - first_en_cyc), 64'(exp_span));
    end
  endtask

  typedef struct {
    logic [255:0] spikes;
    int           sram_mode;
    int           ready_mode;
    int           exp_words;
    int           exp_span;   // -1: issue rate not checked
  } vec_t;

  function automatic logic [255:0] random_spikes();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom() & $urandom() & $urandom();
    return v;
  endfunction

  initial begin
    vec_t         vecs[6];
    logic [255:0] sp3, sp8, b0, b255;
    int           d0;

    sp3 = '0; sp3[3] = 1'b1; sp3[17] = 1'b1; sp3[255] = 1'b1;
    sp8 = '0;
    sp8[1] = 1'b1; sp8[2] = 1'b1; sp8[40] = 1'b1; sp8[63] = 1'b1;
    sp8[64] = 1'b1; sp8[128] = 1'b1; sp8[200] = 1'b1; sp8[254] = 1'b1;
    b0 = '0; b0[0] = 1'b1;
    b255 = '0; b255[255] = 1'b1;
    vecs[0] = '{sp3,    0, 0, 3,   2};
    vecs[1] = '{'1,     0, 0, 256, 255};
    vecs[2] = '{'0,     0, 0, 0,   -1};
    vecs[3] = '{sp8,    1, 1, 8,   -1};
    vecs[4] = '{b0,     1, 0, 1,   0};
    vecs[5] = '{b255,   0, 1, 1,   -1};

    rst_i = 1'b1;
    start_i = 1'b0;
    spikes_i = '0;
    setup_sram(0);
    repeat (3) tick();
    check("reset_outputs", 64'({syn_en_o, syn_we_o, syn_addr_o, conn_valid_o, conn_data_o,
                                conn_axon_o, conn_last_o, busy_o, done_o}), 64'd0);
    rst_i = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      setup_sram(vecs[v].sram_mode);
      run_scan(vecs[v].spikes, vecs[v].ready_mode);
      scan_checks(vecs[v].exp_words, vecs[v].exp_span);
    end

    for (int r = 0; r < 6; r++) begin
      logic [255:0] sp;
      sp = random_spikes();
      setup_sram(1);
      run_scan(sp, 1);
      scan_checks($countones(sp), -1);
    end

    // Reset mid-scan while a read is in flight: scan abandoned, no done, no stray word.
    setup_sram(0);
    d0 = done_count;
    ready_mode = 0;
    spikes_i = '1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    rst_i = 1'b1;
    repeat (2) tick();
    check("midscan_reset_outputs", 64'({syn_en_o, syn_we_o, syn_addr_o, conn_valid_o,
                                        conn_data_o, conn_axon_o, conn_last_o, busy_o,
                                        done_o}), 64'd0);
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_quiet", 64'({syn_en_o, conn_valid_o, busy_o, done_o}), 64'd0);
    end
    check("no_done_on_reset", 64'(done_count - d0), 64'd0);

    // Restart after reset; a second start during the scan must be ignored.
    d0 = done_count;
    ready_mode = 1;
    spikes_i = sp3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    spikes_i = '1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(d0, 2000);
    scan_checks(3, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
